// File: rtl/noc_pkg.sv
// Shared NoC types: port encoding, flit format and per-VC state.
package noc_pkg;

    localparam int PORT_NUM  = 5;
    localparam int PORT_W    = $clog2(PORT_NUM);
    localparam int VC_ID_W   = 1;
    localparam int PAYLOAD_W = 16;

    typedef logic [PORT_W-1:0] port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        port_t                out_port;   // lookahead route, valid on head flits
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/input_port_unit_circular_buffer.sv
// Circular FIFO of flits with a combinational front and full/empty flags.
module circular_buffer
    import noc_pkg::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  write_i,
    input  logic  read_i,
    output flit_t data_o,
    output logic  is_full_o,
    output logic  is_empty_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    flit_t            mem [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_write;
    logic             do_read;

    assign is_full_o  = (count == CNT_W'(BUFFER_SIZE));
    assign is_empty_o = (count == '0);
    assign do_write   = write_i && !is_full_o;
    assign do_read    = read_i && !is_empty_o;
    assign data_o     = mem[rd_ptr];

    // Flit storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally; a write and read together keep the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: per-VC flit buffers, per-VC packet FSM, switch-allocation
// requests and a registered crossbar output with upstream credit pulses.
module input_port_unit
    import noc_pkg::*;
#(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               data_i,
    input  logic                valid_i,
    output logic [VC_NUM-1:0]   credit_o,
    output logic [VC_NUM-1:0]   request_o,
    output port_t [VC_NUM-1:0]  out_port_o,
    input  logic [VC_NUM-1:0]   grant_i,
    input  logic [PORT_NUM-1:0] out_ready_i,
    output flit_t               xb_flit_o,
    output logic                xb_valid_o,
    output port_t               xb_port_o,
    output logic                error_o
);

    localparam int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    flit_t             front [VC_NUM];
    logic [VC_NUM-1:0] full;
    logic [VC_NUM-1:0] empty;
    logic [VC_NUM-1:0] write_en;
    logic [VC_NUM-1:0] read_en;
    logic [VC_NUM-1:0] discard;
    logic [VC_NUM-1:0] pop_gnt;
    vc_state_t         state [VC_NUM];
    port_t             port_q [VC_NUM];

    logic [(2**PORT_W)-1:0] ready_ext;
    logic                   write_drop;
    logic                   gnt_any;
    logic                   gnt_multi;
    logic                   gnt_ok;
    logic                   gnt_bad;
    logic [VC_IDX_W-1:0]    gnt_sel;

    // Zero-extend so any encodable latched port indexes a defined bit.
    assign ready_ext = (2**PORT_W)'(out_ready_i);

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        circular_buffer #(
            .BUFFER_SIZE(BUFFER_SIZE)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .data_i    (data_i),
            .write_i   (write_en[g]),
            .read_i    (read_en[g]),
            .data_o    (front[g]),
            .is_full_o (full[g]),
            .is_empty_o(empty[g])
        );
    end

    // Requests and latched ports come from registered state and out_ready_i only.
    always_comb begin
        request_o = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            out_port_o[v] = port_q[v];
            request_o[v]  = (state[v] == VC_ACTIVE) && !empty[v] && ready_ext[port_q[v]];
        end
    end

    // Pick the lowest grant bit; extra bits or a grant without request are errors.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_multi = 1'b0;
        gnt_sel   = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (grant_i[v]) begin
                if (gnt_any) begin
                    gnt_multi = 1'b1;
                end else begin
                    gnt_any = 1'b1;
                    gnt_sel = VC_IDX_W'(v);
                end
            end
        end
        gnt_ok  = gnt_any && request_o[gnt_sel];
        gnt_bad = gnt_multi || (gnt_any && !request_o[gnt_sel]);
    end

    // Buffer write/read strobes: full is judged before any same-edge pop.
    always_comb begin
        write_en   = '0;
        read_en    = '0;
        discard    = '0;
        pop_gnt    = '0;
        write_drop = 1'b0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (valid_i && (data_i.vc_id == VC_ID_W'(v))) begin
                if (full[v]) begin
                    write_drop = 1'b1;
                end else begin
                    write_en[v] = 1'b1;
                end
            end
            discard[v] = (state[v] == VC_IDLE) && !empty[v] && !is_head(front[v].flit_label);
            pop_gnt[v] = gnt_ok && (gnt_sel == VC_IDX_W'(v));
            read_en[v] = discard[v] || pop_gnt[v];
        end
    end

    // Per-VC packet FSMs, port latches, crossbar output register and error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                state[v]  <= VC_IDLE;
                port_q[v] <= '0;
            end
            credit_o   <= '0;
            xb_valid_o <= 1'b0;
            xb_flit_o  <= '0;
            xb_port_o  <= '0;
            error_o    <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                case (state[v])
                    VC_IDLE: begin
                        if (!empty[v] && is_head(front[v].flit_label)) begin
                            state[v]  <= VC_ACTIVE;
                            port_q[v] <= front[v].out_port;
                        end
                    end
                    VC_ACTIVE: begin
                        if (pop_gnt[v] && is_tail(front[v].flit_label)) begin
                            state[v] <= VC_IDLE;
                        end
                    end
                    default: state[v] <= VC_IDLE;
                endcase
            end

            credit_o   <= '0;
            xb_valid_o <= gnt_ok;
            if (gnt_ok) begin
                credit_o[gnt_sel] <= 1'b1;
                xb_flit_o         <= front[gnt_sel];
                xb_port_o         <= port_q[gnt_sel];
            end

            if (write_drop || (|discard) || gnt_bad) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule
